// File: rtl/seq1011_tx.sv
// Serial MSB-first word transmitter driving the 1011 detector's x input, BIT_CYCLES clocks per bit.
// Optional golden detector model and match counter enabled by SEQ1011_EXPECT_EN.
module seq1011_tx #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             x,
    output logic             x_valid,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
`ifdef SEQ1011_EXPECT_EN
    ,
    output logic             exp_y,
    output logic [LEN_W-1:0] exp_cnt
`endif
);

    localparam int unsigned      HOLD_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               bit_stb_q, bit_stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_ready_q, load_ready_d;

    logic [LEN_W-1:0]   len_eff;
    logic [WIDTH-1:0]   aligned;
    logic               accept;
    logic               last_hold;
    logic               last_bit;

    // Left-align the word so bit len-1 sits at the MSB and shifts out first.
    assign len_eff   = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;
    assign aligned   = load_data << (LEN_MAX - len_eff);
    assign accept    = (state_q == StIdle) && load_valid && load_ready_q;
    assign last_hold = (hold_q == HOLD_LAST);
    assign last_bit  = (bit_q == len_q - LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        len_d        = len_q;
        bit_d        = bit_q;
        hold_d       = hold_q;
        x_d          = x_q;
        x_valid_d    = x_valid_q;
        bit_stb_d    = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_ready_d = load_ready_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d      = StShift;
                    sr_d         = aligned << 1;
                    x_d          = aligned[WIDTH-1];
                    len_d        = len_eff;
                    bit_d        = '0;
                    hold_d       = '0;
                    x_valid_d    = 1'b1;
                    bit_stb_d    = 1'b1;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
                end
            end
            StShift: begin
                if (!last_hold) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (last_bit) begin
                    state_d   = StDone;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    x_d       = sr_q[WIDTH-1];
                    sr_d      = sr_q << 1;
                    bit_d     = bit_q + LEN_W'(1);
                    hold_d    = '0;
                    bit_stb_d = 1'b1;
                end
            end
            StDone: begin
                state_d      = StIdle;
                load_ready_d = 1'b1;
            end
            default: begin
                state_d      = StIdle;
                load_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            len_q        <= '0;
            bit_q        <= '0;
            hold_q       <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            bit_stb_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            len_q        <= len_d;
            bit_q        <= bit_d;
            hold_q       <= hold_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            bit_stb_q    <= bit_stb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign bit_stb    = bit_stb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

`ifdef SEQ1011_EXPECT_EN
    typedef enum logic [1:0] {DetNone, DetOne, DetOneZero, DetOneZeroOne} det_e;

    det_e             det_q, det_d;
    logic             exp_y_q, exp_y_d;
    logic [LEN_W-1:0] exp_cnt_q, exp_cnt_d;
    logic             bit_end;
    logic             match;

    // The detector consumes x_q as each bit period closes, so exp_y covers the following period.
    assign bit_end = (state_q == StShift) && last_hold;
    assign match   = (det_q == DetOneZeroOne) && x_q;

    always_comb begin
        det_d     = det_q;
        exp_y_d   = exp_y_q;
        exp_cnt_d = exp_cnt_q;
        if (accept) begin
            det_d     = DetNone;
            exp_y_d   = 1'b0;
            exp_cnt_d = '0;
        end else if (bit_end) begin
            exp_y_d = match;
            if (match) begin
                exp_cnt_d = exp_cnt_q + LEN_W'(1);
            end
            unique case (det_q)
                DetNone:       det_d = x_q ? DetOne : DetNone;
                DetOne:        det_d = x_q ? DetOne : DetOneZero;
                DetOneZero:    det_d = x_q ? DetOneZeroOne : DetNone;
                DetOneZeroOne: det_d = x_q ? DetOne : DetOneZero;
                default:       det_d = DetNone;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det_q     <= DetNone;
            exp_y_q   <= 1'b0;
            exp_cnt_q <= '0;
        end else begin
            det_q     <= det_d;
            exp_y_q   <= exp_y_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    assign exp_y   = exp_y_q;
    assign exp_cnt = exp_cnt_q;
`endif

endmodule

// File: tb/tb_seq1011_tx.sv
// Directed bench for seq1011_tx: one instance with BIT_CYCLES=1 and one with BIT_CYCLES=5.
module tb_seq1011_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lv   [2];
    logic [19:0] ld   [2];
    logic [4:0]  ll   [2];
    logic        rdy  [2];
    logic        x    [2];
    logic        xv   [2];
    logic        stb  [2];
    logic        busy [2];
    logic        done [2];
`ifdef SEQ1011_EXPECT_EN
    logic        ey   [2];
    logic [4:0]  ec   [2];
`endif

    int passed = 0;
    int total  = 0;

    seq1011_tx #(.WIDTH(20), .LEN_W(5), .BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld[0]),
        .load_len(ll[0]), .x(x[0]), .x_valid(xv[0]), .bit_stb(stb[0]), .busy(busy[0]),
        .done(done[0])
`ifdef SEQ1011_EXPECT_EN
        , .exp_y(ey[0]), .exp_cnt(ec[0])
`endif
    );

    seq1011_tx #(.WIDTH(20), .LEN_W(5), .BIT_CYCLES(5)) u_dut5 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld[1]),
        .load_len(ll[1]), .x(x[1]), .x_valid(xv[1]), .bit_stb(stb[1]), .busy(busy[1]),
        .done(done[1])
`ifdef SEQ1011_EXPECT_EN
        , .exp_y(ey[1]), .exp_cnt(ec[1])
`endif
    );

    typedef struct {
        logic        lv;
        logic [19:0] ld;
        logic [4:0]  ll;
        logic [5:0]  exp;  // {x, x_valid, bit_stb, busy, done, load_ready}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [5:0] obs(input int s);
        return {x[s], xv[s], stb[s], busy[s], done[s], rdy[s]};
    endfunction

    // Period k is flagged when the four preceding bits were 1,0,1,1.
    function automatic logic win(input logic [19:0] d, input int len, input int k);
        if (k < 4) return 1'b0;
        return d[len-1-(k-4)] && !d[len-1-(k-3)] && d[len-1-(k-2)] && d[len-1-(k-1)];
    endfunction

    task automatic load(input int s, input logic [19:0] data, input logic [4:0] len,
                        input bit keep);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[s] && n < 300);
        if (!rdy[s]) begin
            chk("load_ready_timeout", 32'(rdy[s]), 32'd1);
            return;
        end
        lv[s] = 1'b1;
        ld[s] = data;
        ll[s] = len;
        @(posedge clk);
        #1;
        if (!keep) lv[s] = 1'b0;
    endtask

    // Checks every cycle from the first bit through the done pulse.
    task automatic expect_word(input int s, input logic [19:0] data, input int len);
        int bc = (s == 1) ? 5 : 1;
`ifdef SEQ1011_EXPECT_EN
        int cnt = 0;
`endif
        for (int k = 0; k < len; k++) begin
            for (int h = 0; h < bc; h++) begin
                @(negedge clk);
                chk($sformatf("bit%0d_h%0d", k, h), 32'(obs(s)),
                    32'({data[len-1-k], 1'b1, (h == 0), 1'b1, 1'b0, 1'b0}));
`ifdef SEQ1011_EXPECT_EN
                chk($sformatf("exp_y_p%0d", k), 32'(ey[s]), 32'(win(data, len, k)));
`endif
            end
        end
        @(negedge clk);
        chk("done_cycle", 32'(obs(s)), 32'b000010);
`ifdef SEQ1011_EXPECT_EN
        for (int k = 4; k <= len; k++) cnt += int'(win(data, len, k));
        chk("exp_y_done", 32'(ey[s]), 32'(win(data, len, len)));
        chk("exp_cnt_done", 32'(ec[s]), 32'(cnt));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        tbl[0]  = '{1'b1, 20'hB, 5'd4, 6'b111101 & 6'b111100};
        tbl[1]  = '{1'b0, 20'h0, 5'd0, 6'b011100};
        tbl[2]  = '{1'b0, 20'h0, 5'd0, 6'b111100};
        tbl[3]  = '{1'b0, 20'h0, 5'd0, 6'b111100};
        tbl[4]  = '{1'b0, 20'h0, 5'd0, 6'b000010};
        tbl[5]  = '{1'b0, 20'h0, 5'd0, 6'b000001};
        tbl[6]  = '{1'b1, 20'h6, 5'd3, 6'b111100};
        tbl[7]  = '{1'b0, 20'h0, 5'd0, 6'b111100};
        tbl[8]  = '{1'b0, 20'h0, 5'd0, 6'b011100};
        tbl[9]  = '{1'b0, 20'h0, 5'd0, 6'b000010};
        tbl[10] = '{1'b0, 20'h0, 5'd0, 6'b000001};

        for (int s = 0; s < 2; s++) begin
            lv[s] = 1'b0;
            ld[s] = '0;
            ll[s] = '0;
        end

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_dut1", 32'(obs(0)), 32'b000001);
            chk("idle_dut5", 32'(obs(1)), 32'b000001);
        end
`ifdef SEQ1011_EXPECT_EN
        chk("exp_reset", 32'({ey[1], ec[1]}), 32'd0);
`endif

        // Basic word 1011 then 110, table-driven on the BIT_CYCLES=1 instance
        for (int i = 0; i < 11; i++) begin
            lv[0] = tbl[i].lv;
            ld[0] = tbl[i].ld;
            ll[0] = tbl[i].ll;
            @(negedge clk);
            chk($sformatf("tbl%0d", i), 32'(obs(0)), 32'(tbl[i].exp));
        end
        lv[0] = 1'b0;

        // Hold timing, 20 bits at 5 clocks each
        load(1, 20'hD8B69, 5'd20, 1'b0);
        expect_word(1, 20'hD8B69, 20);
`ifdef SEQ1011_EXPECT_EN
        chk("exp_cnt_d8b69", 32'(ec[1]), 32'd3);
`endif
        @(negedge clk);
        chk("ready_after_done", 32'(obs(1)), 32'b000001);

        // Length clamp: 0 and 25 both send 20 bits
        load(1, 20'hA5F03, 5'd0, 1'b0);
        expect_word(1, 20'hA5F03, 20);
        load(0, 20'h3C96B, 5'd25, 1'b0);
        expect_word(0, 20'h3C96B, 20);

        // load_valid held through a word; changed data must not be captured until ready
        load(0, 20'h000B3, 5'd8, 1'b1);
        ld[0] = 20'hFFFFD;
        ll[0] = 5'd4;
        expect_word(0, 20'h000B3, 8);
        @(negedge clk);
        chk("hs_idle", 32'(obs(0)), 32'b000001);
        @(posedge clk);
        #1 lv[0] = 1'b0;
        expect_word(0, 20'hFFFFD, 4);

        // Mid-word reset at bit 7
        load(1, 20'hD8B69, 5'd20, 1'b0);
        repeat (35) @(negedge clk);
        @(negedge clk);
        chk("bit7_before_rst", 32'(obs(1)), 32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_forced", 32'(obs(1)), 32'b000001);
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(obs(1)), 32'b000001);
        end
`ifdef SEQ1011_EXPECT_EN
        chk("exp_after_rst", 32'({ey[1], ec[1]}), 32'd0);
`endif
        load(1, 20'h2D6B5, 5'd20, 1'b0);
        expect_word(1, 20'h2D6B5, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
